alu_iter: RTL

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes RV32I integer ops in one cycle and RV32M multiply/divide ops iteratively. Results are registered and held behind a valid/ready output handshake. It sits between operand select and writeback, and stalls the pipeline through `in_ready` while a multi-cycle op runs.

---
 rtl/alu_iter_pkg.sv | 46 ++++
 rtl/alu_iter_if.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 113 +++++++++++
 rtl/alu_iter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Opcode and state enums, default width and op-class helper
//               shared by the iterative ALU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_if.sv
//==============================================================================
// Module      : alu_iter_if
// Description : Request/response handshake bundle of the iterative ALU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_iter_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, alu_op, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, alu_op, operand1, operand2, out_ready,
        output in_ready, out_valid, result, illegal
    );

endinterface

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
//==============================================================================
// Module      : alu_muldiv_iter
// Description : Radix-2 shift-add multiplier / restoring divider on magnitudes,
//               one bit per cycle, sharing one working register and adder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] res
);

    logic [2*XLEN-1:0] r_work;
    logic [XLEN-1:0]   r_m;
    logic [CW-1:0]     r_cnt;
    logic              r_run;
    logic              r_div;
    logic              r_hi_sel;
    logic              r_neg;

    logic              w_is_div;
    logic              w_na;
    logic              w_nb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN-1:0] w_nxt;
    logic [XLEN-1:0]   w_sel;
    logic              w_inc;

    // Entry fix-up: iterate on magnitudes, remember how to sign the result
    always_comb begin
        w_is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_na     = (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[XLEN-1];
        w_nb     = (op inside {OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
        w_mag_a  = w_na ? (~a + 1'b1) : a;
        w_mag_b  = w_nb ? (~b + 1'b1) : b;
        case (op)
            OP_DIV, OP_DIVU: w_neg = (w_na ^ w_nb) && (b != '0);
            OP_REM, OP_REMU: w_neg = w_na;
            default:         w_neg = w_na ^ w_nb;
        endcase
    end

    // Division subtracts via inverted operand + carry-in; bit XLEN+1 is "no borrow"
    always_comb begin
        w_shift = {r_work[2*XLEN-1:XLEN], r_work[XLEN-1]};
        w_add_a = r_div ? w_shift : {1'b0, r_work[2*XLEN-1:XLEN]};
        w_add_b = r_div ? ~{1'b0, r_m} : {1'b0, (r_work[0] ? r_m : '0)};
        w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, r_div};
        if (r_div) begin
            w_nxt[2*XLEN-1:XLEN] = w_sum[XLEN+1] ? w_sum[XLEN-1:0] : w_shift[XLEN-1:0];
            w_nxt[XLEN-1:0]      = {r_work[XLEN-2:0], w_sum[XLEN+1]};
        end else begin
            w_nxt[2*XLEN-1:XLEN] = w_sum[XLEN:1];
            w_nxt[XLEN-1:0]      = {w_sum[0], r_work[XLEN-1:1]};
        end
    end

    // Exit fix-up on the final iteration's value; high-half negation borrows from the low half
    always_comb begin
        w_sel = r_hi_sel ? w_nxt[2*XLEN-1:XLEN] : w_nxt[XLEN-1:0];
        w_inc = (!r_div && r_hi_sel) ? (w_nxt[XLEN-1:0] == '0) : 1'b1;
        res   = r_neg ? (~w_sel + {{(XLEN-1){1'b0}}, w_inc}) : w_sel;
        done  = r_run && (r_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_div    <= 1'b0;
            r_hi_sel <= 1'b0;
            r_neg    <= 1'b0;
        end else if (start) begin
            r_work   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_m      <= w_is_div ? w_mag_b : w_mag_a;
            r_cnt    <= CW'(XLEN - 1);
            r_run    <= 1'b1;
            r_div    <= w_is_div;
            r_hi_sel <= op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            r_neg    <= w_neg;
        end else if (r_run) begin
            r_work <= w_nxt;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
//==============================================================================
// Module      : alu_iter
// Description : Handshaked ALU: RV32I ops in one cycle, RV32M ops iterative.
//               Define ALU_ITER_MULDIV_EN to build the multiply/divide unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_iter_if.slave bus
);

    alu_state_e      r_state;
    alu_state_e      w_state_nxt;
    alu_state_e      w_go_state;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    alu_op_e         w_op;
    logic            w_accept;
    logic            w_md;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sc_res;
    logic            w_sc_ill;

    assign w_op     = alu_op_e'(bus.alu_op);
    assign w_shamt  = bus.operand2[SHW-1:0];
    assign w_accept = bus.in_valid && bus.in_ready;

`ifdef ALU_ITER_MULDIV_EN
    logic            w_md_done;
    logic [XLEN-1:0] w_md_res;

    assign w_md       = is_muldiv(w_op);
    assign w_go_state = w_md ? BUSY : DONE;

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && w_md),
        .op    (w_op),
        .a     (bus.operand1),
        .b     (bus.operand2),
        .done  (w_md_done),
        .res   (w_md_res)
    );
`else
    assign w_md       = 1'b0;
    assign w_go_state = DONE;
`endif

    // M opcodes fall into default here; the iterative path overrides them when built
    always_comb begin
        w_sc_res = '0;
        w_sc_ill = 1'b0;
        case (w_op)
            OP_ADD:  w_sc_res = bus.operand1 + bus.operand2;
            OP_SUB:  w_sc_res = bus.operand1 - bus.operand2;
            OP_AND:  w_sc_res = bus.operand1 & bus.operand2;
            OP_OR:   w_sc_res = bus.operand1 | bus.operand2;
            OP_XOR:  w_sc_res = bus.operand1 ^ bus.operand2;
            OP_SLL:  w_sc_res = bus.operand1 << w_shamt;
            OP_SRL:  w_sc_res = bus.operand1 >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(bus.operand1) >>> w_shamt);
            OP_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(bus.operand1) < $signed(bus.operand2))};
            OP_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (bus.operand1 < bus.operand2)};
            default: w_sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = w_go_state;
            end
`ifdef ALU_ITER_MULDIV_EN
            BUSY: begin
                if (w_md_done) w_state_nxt = DONE;
            end
`endif
            DONE: begin
                if (w_accept)           w_state_nxt = w_go_state;
                else if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (r_state == DONE);
        bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    end

    // Result only moves on accept or completion, so it holds while stalled in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_md) begin
            r_result  <= w_sc_res;
            r_illegal <= w_sc_ill;
        end
`ifdef ALU_ITER_MULDIV_EN
        else if ((r_state == BUSY) && w_md_done) begin
            r_result  <= w_md_res;
            r_illegal <= 1'b0;
        end
`endif
    end

    assign bus.result  = r_result;
    assign bus.illegal = r_illegal;

endmodule

`default_nettype wire
